// File: rtl/stopwatch_bcd.sv
// BCD stopwatch: debounced start/clear/lap keys, run/stop FSM, carry-chain counter, 7-seg drive.
// Optional lap-freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned TICK_HZ      = 100,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned DEBOUNCE_CYC = 500_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                KEY_START_N,
    input  logic                KEY_CLEAR_N,
    input  logic                KEY_LAP_N,
    output logic [7*DIGITS-1:0] HEX_SEG,
    output logic                RUNNING,
    output logic                OVERFLOW,
    output logic                LAP_ACTIVE
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYC + 1);
`ifdef STOPWATCH_LAP_EN
    localparam int unsigned NKEYS = 3;
`else
    localparam int unsigned NKEYS = 2;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StStop, StFull} state_e;

    // ---------------- key conditioning ----------------
    logic [NKEYS-1:0] key_raw;
    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic [NKEYS-1:0] deb_q, deb_d;
    logic [NKEYS-1:0] press_q, press_d;
    logic [DBW-1:0]   db_cnt_q [NKEYS];
    logic [DBW-1:0]   db_cnt_d [NKEYS];

    always_comb begin
        key_raw    = '1;
        key_raw[0] = KEY_START_N;
        key_raw[1] = KEY_CLEAR_N;
`ifdef STOPWATCH_LAP_EN
        key_raw[2] = KEY_LAP_N;
`endif
    end

`ifndef STOPWATCH_LAP_EN
    logic key_lap_unused;
    assign key_lap_unused = KEY_LAP_N;
`endif

    // Level is accepted once the synced key has disagreed with it for DEBOUNCE_CYC cycles in a row.
    always_comb begin
        for (int k = 0; k < NKEYS; k++) begin
            deb_d[k]    = deb_q[k];
            db_cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (db_cnt_q[k] == DBW'(DEBOUNCE_CYC - 1)) begin
                    deb_d[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DBW'(1);
                end
            end
        end
        press_d = deb_q & ~deb_d;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            press_q <= '0;
            for (int k = 0; k < NKEYS; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int k = 0; k < NKEYS; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
        end
    end

    logic start_p, clear_p;
    assign start_p = press_q[0];
    assign clear_p = press_q[1];

    // ---------------- counter core ----------------
    state_e                  state_q, state_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [DIGITS-1:0][3:0]  cnt_q, cnt_d, cnt_inc, disp;
    logic                    running_q, overflow_q;
    logic                    tick, all9, carry;

    always_comb begin
        all9    = 1'b1;
        carry   = 1'b1;
        cnt_inc = cnt_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (cnt_q[k] != 4'd9) begin
                all9 = 1'b0;
            end
            if (carry) begin
                if (cnt_q[k] == 4'd9) begin
                    cnt_inc[k] = 4'd0;
                end else begin
                    cnt_inc[k] = cnt_q[k] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic                   lap_p;
    logic                   lap_act_q, lap_act_d;
    logic [DIGITS-1:0][3:0] lap_q, lap_d;
    assign lap_p = press_q[2];
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        tick    = (state_q == StRun) && (presc_q == PW'(DIV - 1));
`ifdef STOPWATCH_LAP_EN
        lap_d     = lap_q;
        lap_act_d = lap_act_q;
`endif
        if (clear_p) begin
            state_d = StIdle;
            presc_d = '0;
            cnt_d   = '0;
`ifdef STOPWATCH_LAP_EN
            lap_act_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: if (start_p) state_d = StRun;
                StRun: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (all9) state_d = StFull;
                        else      cnt_d   = cnt_inc;
                    end
                    // Saturation takes precedence over a coincident start press.
                    if (start_p && !(tick && all9)) state_d = StStop;
                end
                StStop: if (start_p) state_d = StRun;
                StFull: ;
                default: state_d = StIdle;
            endcase
`ifdef STOPWATCH_LAP_EN
            if (lap_p && (state_q == StRun || state_q == StFull)) begin
                if (lap_act_q) begin
                    lap_act_d = 1'b0;
                end else begin
                    lap_d     = cnt_q;
                    lap_act_d = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            cnt_q      <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            running_q  <= (state_d == StRun);
            overflow_q <= (state_d == StFull);
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            lap_q     <= '0;
            lap_act_q <= 1'b0;
        end else begin
            lap_q     <= lap_d;
            lap_act_q <= lap_act_d;
        end
    end

    assign disp       = lap_act_q ? lap_q : cnt_q;
    assign LAP_ACTIVE = lap_act_q;
`else
    assign disp       = cnt_q;
    assign LAP_ACTIVE = 1'b0;
`endif

    assign RUNNING  = running_q;
    assign OVERFLOW = overflow_q;

    // ---------------- 7-segment decode (gfedcba, active low) ----------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        HEX_SEG = '1;
        for (int k = 0; k < DIGITS; k++) begin
            HEX_SEG[7*k +: 7] = seg7(disp[k]);
        end
    end

endmodule
